cv32e40s_rvfi_instr_obi: RTL and testbench
==========================================

// Module: cv32e40s_rvfi_instr_obi
// PURPOSE
// Tracks the instruction-side OBI bus for RVFI.
// - Each accepted address phase (req&gnt) is queued with its PMP status.
// - On each response phase (rvalid) the queue head is paired with the response payload.
// - The paired record is emitted as an rvfi_obi_instr_t through a valid/ready output queue.
// - The RVFI stage consumes the output queue to annotate fetches on retiring instructions.
// - Sits between the core's instruction OBI interface and the RVFI reporting stage.
// PARAMETERS
// A_DEPTH   2  max outstanding address phases tracked (>=1)
// R_DEPTH   4  output record queue depth (>=1)
// PORTS
// clk                  in   1                        clock
// rst_n                in   1                        async active-low reset
// obi_req_i            in   1                        instr OBI req
// obi_gnt_i            in   1                        instr OBI gnt
// obi_req_payload_i    in   $bits(obi_inst_req_t)    address-phase payload
// pmp_err_i            in   1                        PMP status, valid when req&gnt
// obi_rvalid_i         in   1                        instr OBI rvalid
// obi_resp_payload_i   in   $bits(inst_resp_t)       response payload, valid when rvalid
// rec_valid_o          out  1                        output record available
// rec_ready_i          in   1                        consumer takes record
// rec_o                out  $bits(rvfi_obi_instr_t)  {req_payload, resp_payload, pmp_err}
// outstanding_o        out  $clog2(A_DEPTH+1)        address phases awaiting response
// err_overflow_o       out  1                        sticky: a queue push was dropped
// err_orphan_o         out  1                        sticky: rvalid with no outstanding request
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - both queues empty; all outputs 0, including rec_o and both sticky errors.
//   - Reset mid-transaction discards all queued entries.
// - A-queue: circular FIFO, A_DEPTH entries of {obi_req_payload_i, pmp_err_i}; wr/rd pointers wrap modulo A_DEPTH.
//   - push = obi_req_i & obi_gnt_i;  pop = obi_rvalid_i & (count!=0).
//   - push when full and no pop: entry dropped, err_overflow_o set.
//   - push and pop in same cycle when full: both occur, count unchanged.
//   - rvalid with count==0: err_orphan_o set, nothing paired or pushed to R-queue.
//     - A push granted in the same cycle is still queued; OBI forbids rvalid in the gnt cycle.
//   - outstanding_o = A-queue count (registered).
// - Pairing: on pop, {head.req_payload, obi_resp_payload_i, head.pmp_err} is pushed to the R-queue in the same cycle.
// - R-queue: circular FIFO, R_DEPTH entries.
//   - rec_valid_o = !empty; rec_o = head entry (registered storage).
//   - pop = rec_valid_o & rec_ready_i.
//   - push when full and no pop: record dropped, err_overflow_o set.
//   - push and pop in same cycle when full: both occur.
//   - push when empty: visible on rec_valid_o the next cycle.
// - Latency: rvalid in cycle N -> rec_valid_o=1 in cycle N+1 (R-queue empty before).
// - Records leave strictly in OBI response order (OBI instr responses are in-order).
// - The OBI side is never backpressured.
//   - rec_ready_i low only fills the R-queue; it does not stall the bus.
// - Sticky errors clear only on reset.
// - rec_valid_o/rec_o are stable while rec_valid_o & !rec_ready_i.
// - No combinational path from any input to rec_valid_o or rec_o.
// TESTING
// 1. Single fetch, rec_ready_i=1:
//    - Stimulus: req&gnt, addr=0x0000_0080, pmp_err=0; rvalid 2 cycles later, rdata=0x0000_0013.
//    - Response: rec_valid_o=1 one cycle after rvalid; rec_o carries addr 0x80, rdata 0x13, pmp_err 0.
//    - outstanding_o sequence: 0,1,1,0.
// 2. Two back-to-back grants, addr 0x100 then 0x104 with pmp_err=1 on the second; responses 0xAAAA_AAAA, 0xBBBB_BBBB:
//    - Response: records in order (0x100,0xAAAA_AAAA,0) then (0x104,0xBBBB_BBBB,1).
//    - outstanding_o peaks at 2.
// 3. A_DEPTH=2, two outstanding, third req&gnt without rvalid:
//    - Response: err_overflow_o=1, outstanding_o stays 2.
//    - Same scenario with a simultaneous rvalid: no error, count stays 2.
// 4. rvalid with nothing outstanding:
//    - Response: err_orphan_o=1, rec_valid_o stays 0, outstanding_o stays 0.
// 5. rec_ready_i=0, R_DEPTH=4, five paired responses:
//    - Response: first four held with rec_o stable; fifth dropped, err_overflow_o=1.
//    - Raising rec_ready_i drains exactly 4 records in order.
// 6. Reset mid-operation:
//    - Stimulus: assert rst_n=0 with 1 outstanding request and 2 queued records.
//    - Response: outputs 0 immediately.
//    - After release, a new fetch yields exactly one record; no stale data appears.

Source files
------------

// File: rtl/cv32e40s_rvfi_instr_obi.sv
// Pairs instruction OBI address phases with their responses and queues the records for RVFI.
// Latency: rvalid in cycle N gives rec_valid_o in cycle N+1. The bus is never stalled; a full queue drops the push and raises err_overflow_o.
package cv32e40s_rvfi_obi_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic        dbg;
    } obi_inst_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } inst_resp_t;

    typedef struct packed {
        obi_inst_req_t req_payload;
        inst_resp_t    resp_payload;
        logic          pmp_err;
    } rvfi_obi_instr_t;
endpackage

module cv32e40s_rvfi_instr_obi
    import cv32e40s_rvfi_obi_pkg::*;
#(
    parameter int A_DEPTH = 2,
    parameter int R_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         obi_req_i,
    input  logic                         obi_gnt_i,
    input  obi_inst_req_t                obi_req_payload_i,
    input  logic                         pmp_err_i,
    input  logic                         obi_rvalid_i,
    input  inst_resp_t                   obi_resp_payload_i,
    output logic                         rec_valid_o,
    input  logic                         rec_ready_i,
    output rvfi_obi_instr_t              rec_o,
    output logic [$clog2(A_DEPTH+1)-1:0] outstanding_o,
    output logic                         err_overflow_o,
    output logic                         err_orphan_o
);
    localparam int ACW = $clog2(A_DEPTH+1);
    localparam int RCW = $clog2(R_DEPTH+1);
    localparam int AAW = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam int RAW = (R_DEPTH > 1) ? $clog2(R_DEPTH) : 1;

    obi_inst_req_t   a_req_q [A_DEPTH];
    logic            a_pmp_q [A_DEPTH];
    logic [AAW-1:0]  a_wr_q, a_wr_d, a_rd_q, a_rd_d;
    logic [ACW-1:0]  a_cnt_q, a_cnt_d;

    rvfi_obi_instr_t r_mem_q [R_DEPTH];
    logic [RAW-1:0]  r_wr_q, r_wr_d, r_rd_q, r_rd_d;
    logic [RCW-1:0]  r_cnt_q, r_cnt_d;

    logic            err_overflow_q, err_overflow_d;
    logic            err_orphan_q, err_orphan_d;

    logic a_push_req, a_full, a_push, a_pop;
    logic r_vld, r_full, r_push, r_pop;
    rvfi_obi_instr_t r_new;

    assign a_push_req = obi_req_i & obi_gnt_i;
    assign a_full     = (a_cnt_q == ACW'(A_DEPTH));
    assign a_pop      = obi_rvalid_i & (a_cnt_q != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign a_push     = a_push_req & (~a_full | a_pop);

    assign r_vld  = (r_cnt_q != '0);
    assign r_full = (r_cnt_q == RCW'(R_DEPTH));
    assign r_pop  = r_vld & rec_ready_i;
    assign r_push = a_pop & (~r_full | r_pop);

    assign r_new = '{req_payload:  a_req_q[a_rd_q],
                     resp_payload: obi_resp_payload_i,
                     pmp_err:      a_pmp_q[a_rd_q]};

    always_comb begin
        a_wr_d  = a_wr_q;
        a_rd_d  = a_rd_q;
        r_wr_d  = r_wr_q;
        r_rd_d  = r_rd_q;
        if (a_push) a_wr_d = (a_wr_q == AAW'(A_DEPTH-1)) ? '0 : a_wr_q + 1'b1;
        if (a_pop)  a_rd_d = (a_rd_q == AAW'(A_DEPTH-1)) ? '0 : a_rd_q + 1'b1;
        if (r_push) r_wr_d = (r_wr_q == RAW'(R_DEPTH-1)) ? '0 : r_wr_q + 1'b1;
        if (r_pop)  r_rd_d = (r_rd_q == RAW'(R_DEPTH-1)) ? '0 : r_rd_q + 1'b1;
        a_cnt_d = a_cnt_q + ACW'(a_push) - ACW'(a_pop);
        r_cnt_d = r_cnt_q + RCW'(r_push) - RCW'(r_pop);
        err_overflow_d = err_overflow_q
                       | (a_push_req & a_full & ~a_pop)
                       | (a_pop & r_full & ~r_pop);
        err_orphan_d   = err_orphan_q | (obi_rvalid_i & (a_cnt_q == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_wr_q         <= '0;
            a_rd_q         <= '0;
            a_cnt_q        <= '0;
            r_wr_q         <= '0;
            r_rd_q         <= '0;
            r_cnt_q        <= '0;
            err_overflow_q <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else begin
            a_wr_q         <= a_wr_d;
            a_rd_q         <= a_rd_d;
            a_cnt_q        <= a_cnt_d;
            r_wr_q         <= r_wr_d;
            r_rd_q         <= r_rd_d;
            r_cnt_q        <= r_cnt_d;
            err_overflow_q <= err_overflow_d;
            err_orphan_q   <= err_orphan_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < A_DEPTH; i++) begin
                a_req_q[i] <= '0;
                a_pmp_q[i] <= 1'b0;
            end
            for (int i = 0; i < R_DEPTH; i++) r_mem_q[i] <= '0;
        end else begin
            if (a_push) begin
                a_req_q[a_wr_q] <= obi_req_payload_i;
                a_pmp_q[a_wr_q] <= pmp_err_i;
            end
            if (r_push) r_mem_q[r_wr_q] <= r_new;
        end
    end

    assign rec_valid_o    = r_vld;
    assign rec_o          = r_vld ? r_mem_q[r_rd_q] : '0;
    assign outstanding_o  = a_cnt_q;
    assign err_overflow_o = err_overflow_q;
    assign err_orphan_o   = err_orphan_q;
endmodule

// File: tb/tb_cv32e40s_rvfi_instr_obi.sv
// Directed bench for the instruction OBI tracker: expected records go into a queue, a monitor pops on each handshake.
module tb_cv32e40s_rvfi_instr_obi;
    import cv32e40s_rvfi_obi_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            obi_req_i, obi_gnt_i, pmp_err_i, obi_rvalid_i, rec_ready_i;
    obi_inst_req_t   obi_req_payload_i;
    inst_resp_t      obi_resp_payload_i;
    logic            rec_valid_o, err_overflow_o, err_orphan_o;
    rvfi_obi_instr_t rec_o;
    logic [1:0]      outstanding_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_recs = 0;
    int base;
    rvfi_obi_instr_t exp_q[$];

    always #5 clk = ~clk;

    cv32e40s_rvfi_instr_obi #(.A_DEPTH(2), .R_DEPTH(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .obi_req_i          (obi_req_i),
        .obi_gnt_i          (obi_gnt_i),
        .obi_req_payload_i  (obi_req_payload_i),
        .pmp_err_i          (pmp_err_i),
        .obi_rvalid_i       (obi_rvalid_i),
        .obi_resp_payload_i (obi_resp_payload_i),
        .rec_valid_o        (rec_valid_o),
        .rec_ready_i        (rec_ready_i),
        .rec_o              (rec_o),
        .outstanding_o      (outstanding_o),
        .err_overflow_o     (err_overflow_o),
        .err_orphan_o       (err_orphan_o)
    );

    function automatic obi_inst_req_t mkreq(input logic [31:0] a);
        mkreq = '{addr: a, prot: 3'b100, dbg: 1'b0};
    endfunction

    function automatic rvfi_obi_instr_t mkrec(input logic [31:0] a, input logic [31:0] d, input logic p);
        mkrec = '{req_payload: mkreq(a), resp_payload: '{rdata: d, err: 1'b0}, pmp_err: p};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One bus cycle: inputs applied just after a rising edge, held through the next one.
    task automatic drive(input logic g, input logic [31:0] a, input logic p,
                         input logic rv, input logic [31:0] d);
        obi_req_i          = g;
        obi_gnt_i          = g;
        obi_req_payload_i  = mkreq(a);
        pmp_err_i          = p;
        obi_rvalid_i       = rv;
        obi_resp_payload_i = '{rdata: d, err: 1'b0};
        @(posedge clk); #1;
        obi_req_i    = 1'b0;
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        pmp_err_i    = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rec_valid", rec_valid_o, 0);
        chk("rst_rec", rec_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_overflow", err_overflow_o, 0);
        chk("rst_orphan", err_orphan_o, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rec_valid_o && rec_ready_i) begin
            n_recs++;
            if (exp_q.size() == 0) begin
                chk("unexpected_record", rec_o, 0);
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_record: got %0h expected none", rec_o);
            end else begin
                chk("record", rec_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        obi_req_i = 0; obi_gnt_i = 0; pmp_err_i = 0; obi_rvalid_i = 0;
        obi_req_payload_i = '0; obi_resp_payload_i = '0; rec_ready_i = 1'b1;
        do_reset();

        // Single fetch: outstanding 0,1,1,0
        chk("t1_out0", outstanding_o, 0);
        drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
        chk("t1_out1", outstanding_o, 1);
        idle();
        chk("t1_out2", outstanding_o, 1);
        exp_q.push_back(mkrec(32'h80, 32'h13, 1'b0));
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h13);
        chk("t1_out3", outstanding_o, 0);
        chk("t1_valid", rec_valid_o, 1);
        idle();
        chk("t1_drained", rec_valid_o, 0);

        // Back-to-back grants, second with PMP error
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h104, 1'b1, 1'b0, 32'h0);
        chk("t2_peak", outstanding_o, 2);
        exp_q.push_back(mkrec(32'h100, 32'hAAAA_AAAA, 1'b0));
        exp_q.push_back(mkrec(32'h104, 32'hBBBB_BBBB, 1'b1));
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_AAAA);
        chk("t2_out1", outstanding_o, 1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB_BBBB);
        chk("t2_out0", outstanding_o, 0);
        idle(); idle();

        // A-queue overflow
        drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h204, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h208, 1'b0, 1'b0, 32'h0);
        chk("t3_overflow", err_overflow_o, 1);
        chk("t3_out", outstanding_o, 2);
        exp_q.push_back(mkrec(32'h200, 32'h11, 1'b0));
        exp_q.push_back(mkrec(32'h204, 32'h22, 1'b0));
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h11);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h22);
        idle(); idle();
        chk("t3_out_after", outstanding_o, 0);
        do_reset();

        // Full A-queue with simultaneous pop: no error
        drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h304, 1'b0, 1'b0, 32'h0);
        exp_q.push_back(mkrec(32'h300, 32'h33, 1'b0));
        exp_q.push_back(mkrec(32'h304, 32'h44, 1'b0));
        exp_q.push_back(mkrec(32'h308, 32'h55, 1'b0));
        drive(1'b1, 32'h308, 1'b0, 1'b1, 32'h33);
        chk("t3b_out", outstanding_o, 2);
        chk("t3b_no_overflow", err_overflow_o, 0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h44);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h55);
        idle(); idle();
        chk("t3b_out_after", outstanding_o, 0);
        chk("t3b_no_overflow_after", err_overflow_o, 0);

        // Orphan response
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD);
        chk("t4_orphan", err_orphan_o, 1);
        chk("t4_valid", rec_valid_o, 0);
        chk("t4_out", outstanding_o, 0);
        idle();
        chk("t4_valid_later", rec_valid_o, 0);

        // R-queue fills with consumer stalled, fifth record dropped
        do_reset();
        rec_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h400 + 32'(i*4), 1'b0, 1'b0, 32'h0);
            if (i < 4) exp_q.push_back(mkrec(32'h400 + 32'(i*4), 32'h5000 + 32'(i), 1'b0));
            drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5000 + 32'(i));
            chk("t5_valid_held", rec_valid_o, 1);
            chk("t5_rec_stable", rec_o, mkrec(32'h400, 32'h5000, 1'b0));
        end
        chk("t5_overflow", err_overflow_o, 1);
        base = n_recs;
        rec_ready_i = 1'b1;
        repeat (4) idle();
        chk("t5_drained", rec_valid_o, 0);
        chk("t5_drain_count", n_recs - base, 4);
        chk("t5_queue_empty", exp_q.size(), 0);

        // Reset with one outstanding request and two queued records
        do_reset();
        rec_ready_i = 1'b0;
        drive(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h61);
        drive(1'b1, 32'h504, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h62);
        drive(1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
        chk("t6_out_before", outstanding_o, 1);
        chk("t6_valid_before", rec_valid_o, 1);
        do_reset();
        rec_ready_i = 1'b1;
        base = n_recs;
        drive(1'b1, 32'h700, 1'b0, 1'b0, 32'h0);
        idle();
        exp_q.push_back(mkrec(32'h700, 32'h77, 1'b0));
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h77);
        repeat (3) idle();
        chk("t6_one_record", n_recs - base, 1);
        chk("t6_out_after", outstanding_o, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
